// File: rtl/ahbl_boot_copier.sv
// ahbl_boot_copier: AHB-Lite master that copies WORDS words from the boot ROM
// at SRC_BASE into SRAM at DST_BASE. Each word is read, then written, and the
// read data is summed into a 32-bit checksum.
// All bus outputs are registered. Each transfer is a single NONSEQ address
// phase followed by an IDLE cycle covering its data phase, so a word costs
// four cycles when there are no wait states.
module ahbl_boot_copier #(
  parameter logic [31:0] SRC_BASE = 32'h0000_0000,
  parameter logic [31:0] DST_BASE = 32'h2000_0000,
  parameter int unsigned WORDS    = 16384
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  // Index of the final word. WORDS is at most 2^30, so this fits in 30 bits.
  localparam logic [29:0] LAST_CNT = 30'(WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_D = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t      state_q;
  logic [29:0] cnt_q;
  logic [31:0] dreg_q;
  logic [31:0] checksum_q;
  logic [31:0] haddr_q;
  logic [1:0]  htrans_q;
  logic        hwrite_q;
  logic        busy_q;
  logic        done_q;

  // Address candidates for the next address phase. A 30-bit word index
  // shifted left by two gives a 32-bit byte offset, so the sum wraps
  // modulo 2^32 and the low two bits stay zero.
  logic [29:0] cnt_inc_d;
  logic [31:0] rd_next_addr_d;
  logic [31:0] wr_addr_d;
  logic        last_word_d;

  assign cnt_inc_d      = cnt_q + 30'd1;
  assign rd_next_addr_d = SRC_BASE + {cnt_inc_d, 2'b00};
  assign wr_addr_d      = DST_BASE + {cnt_q, 2'b00};
  assign last_word_d    = (cnt_q == LAST_CNT);

  // Copy sequencer. Bus outputs are loaded on the edge that enters each
  // state, so they are valid for the whole of that state. In a bus state,
  // HREADY low means nothing is updated and every output holds.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dreg_q     <= '0;
      checksum_q <= '0;
      haddr_q    <= '0;
      htrans_q   <= TRANS_IDLE;
      hwrite_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // A new copy starts from word 0 with a cleared checksum. HADDR
          // keeps its last value until the first read is issued.
          if (start) begin
            cnt_q      <= '0;
            checksum_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            htrans_q   <= TRANS_NONSEQ;
            hwrite_q   <= 1'b0;
            haddr_q    <= SRC_BASE;
            state_q    <= ST_RD_A;
          end
        end

        ST_RD_A: begin
          if (HREADY) begin
            htrans_q <= TRANS_IDLE;
            state_q  <= ST_RD_D;
          end
        end

        ST_RD_D: begin
          // Capture the ROM word, fold it into the checksum and issue the
          // matching SRAM write address. HWDATA follows dreg directly.
          if (HREADY) begin
            dreg_q     <= HRDATA;
            checksum_q <= checksum_q + HRDATA;
            htrans_q   <= TRANS_NONSEQ;
            hwrite_q   <= 1'b1;
            haddr_q    <= wr_addr_d;
            state_q    <= ST_WR_A;
          end
        end

        ST_WR_A: begin
          if (HREADY) begin
            htrans_q <= TRANS_IDLE;
            state_q  <= ST_WR_D;
          end
        end

        ST_WR_D: begin
          if (HREADY) begin
            if (last_word_d) begin
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              hwrite_q <= 1'b0;
              state_q  <= ST_DONE;
            end else begin
              cnt_q    <= cnt_inc_d;
              htrans_q <= TRANS_NONSEQ;
              hwrite_q <= 1'b0;
              haddr_q  <= rd_next_addr_d;
              state_q  <= ST_RD_A;
            end
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          htrans_q <= TRANS_IDLE;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign checksum = checksum_q;
  assign HADDR    = haddr_q;
  assign HTRANS   = htrans_q;
  assign HWRITE   = hwrite_q;
  assign HWDATA   = dreg_q;
  assign HSIZE    = 3'b010;

endmodule

// File: tb/tb_ahbl_boot_copier.sv
// Directed testbench for ahbl_boot_copier with a four-word image. It uses a
// zero-latency AHB slave model in which ROM and SRAM share one decoder, and
// it logs every completed data phase.
module tb_ahbl_boot_copier;

  localparam int          WORDS = 4;
  localparam logic [31:0] DST   = 32'h2000_0000;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start = 1'b0;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA;
  logic        busy, done, HWRITE;
  logic [31:0] checksum, HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;

  always #5 HCLK = ~HCLK;

  ahbl_boot_copier #(
    .SRC_BASE(32'h0000_0000),
    .DST_BASE(DST),
    .WORDS   (WORDS)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .checksum(checksum),
    .HADDR   (HADDR),
    .HTRANS  (HTRANS),
    .HSIZE   (HSIZE),
    .HWRITE  (HWRITE),
    .HWDATA  (HWDATA),
    .HREADY  (HREADY),
    .HRDATA  (HRDATA)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct packed {
    logic        busy;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] checksum;
  } snap_t;

  logic [31:0] rom  [0:15];
  logic [31:0] sram [0:15];
  logic        dp_valid;
  logic        dp_write;
  logic [31:0] dp_addr = 32'h0;
  txn_t        log_q[$];
  txn_t        t_new;

  // Slave model: reads come from rom[], indexed by the data-phase address.
  assign HRDATA = rom[dp_addr[5:2]];

  // Track the data phase and record each transfer as it completes.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 32'h0;
    end else if (HREADY) begin
      if (dp_valid) begin
        t_new = '{wr: dp_write, addr: dp_addr, data: (dp_write ? HWDATA : HRDATA)};
        log_q.push_back(t_new);
        if (dp_write) sram[dp_addr[5:2]] <= HWDATA;
        $display("%0t txn %s addr=%h data=%h", $time, dp_write ? "W" : "R", dp_addr, t_new.data);
      end
      dp_valid <= (HTRANS == 2'b10);
      dp_addr  <= HADDR;
      dp_write <= HWRITE;
    end
  end

  // Pulse start and run until done. The bus is stalled two cycles per phase
  // when stall=1. seen is the number of edges after the start edge at which
  // done was first seen high (-1 if never seen). stall_bad counts stalled
  // edges across which a bus output changed.
  task automatic run_copy(input bit stall, input int extra_start_n,
                          output int seen, output snap_t first, output int stall_bad);
    logic [31:0] pa, pw;
    logic [1:0]  pt;
    logic        pwr, prev_rdy;
    seen = -1;
    stall_bad = 0;
    first = '0;
    pa = 0; pw = 0; pt = 0; pwr = 0;
    @(negedge HCLK);
    start = 1'b1;
    HREADY = 1'b1;
    prev_rdy = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge HCLK);
      if (n == 1) first = '{busy: busy, htrans: HTRANS, haddr: HADDR, hwrite: HWRITE, checksum: checksum};
      if (!prev_rdy && (HADDR !== pa || HTRANS !== pt || HWRITE !== pwr || HWDATA !== pw))
        stall_bad++;
      pa = HADDR; pt = HTRANS; pwr = HWRITE; pw = HWDATA;
      if (done === 1'b1) begin
        seen = n - 1;
        break;
      end
      start = (n == extra_start_n);
      prev_rdy = stall ? (((n - 1) % 3) == 2) : 1'b1;
      HREADY = prev_rdy;
    end
    start = 1'b0;
    HREADY = 1'b1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      start  = 1'($urandom_range(0, 1));
      HREADY = 1'($urandom_range(0, 1));
      total++;
      if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HWDATA !== 32'h0 ||
          HSIZE !== 3'b010 || busy !== 1'b0 || done !== 1'b0 || checksum !== 32'h0) begin
        bad++;
        $display("FAIL reset_outputs: got htrans=%b haddr=%h hwrite=%b hwdata=%h hsize=%b busy=%b done=%b cs=%h, want all reset values",
                 HTRANS, HADDR, HWRITE, HWDATA, HSIZE, busy, done, checksum);
      end
    end
    @(negedge HCLK);
    start = 1'b0;
    HREADY = 1'b1;
    HRESETn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      total++;
      if (HTRANS !== 2'b00 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_reset: got htrans=%b busy=%b, want 00 0", HTRANS, busy);
      end
    end
  endtask

  task automatic test_copy();
    int seen, sb;
    snap_t f;
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    rom[0] = 32'd1; rom[1] = 32'd2; rom[2] = 32'd3; rom[3] = 32'd4;
    log_q.delete();
    run_copy(1'b0, -1, seen, f, sb);
    total++;
    if (f.busy !== 1'b1 || f.htrans !== 2'b10 || f.haddr !== 32'h0 || f.hwrite !== 1'b0) begin
      bad++;
      $display("FAIL copy_first_phase: got busy=%b htrans=%b haddr=%h hwrite=%b, want 1 10 00000000 0",
               f.busy, f.htrans, f.haddr, f.hwrite);
    end
    total++;
    if (seen !== 16) begin
      bad++;
      $display("FAIL copy_done_time: got %0d edges, want 16", seen);
    end
    total++;
    if (checksum !== 32'd10) begin
      bad++;
      $display("FAIL copy_checksum: got %h, want 0000000a", checksum);
    end
    total++;
    if (busy !== 1'b0 || HTRANS !== 2'b00 || HWDATA !== 32'd4) begin
      bad++;
      $display("FAIL copy_done_bus: got busy=%b htrans=%b hwdata=%h, want 0 00 00000004", busy, HTRANS, HWDATA);
    end
    total++;
    if (log_q.size() !== 8) begin
      bad++;
      $display("FAIL copy_txn_count: got %0d, want 8", log_q.size());
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        total++;
        if (log_q[2*i] !== '{wr: 1'b0, addr: 32'(4*i), data: 32'(i + 1)}) begin
          bad++;
          $display("FAIL copy_read_%0d: got wr=%b addr=%h data=%h, want R %h %h",
                   i, log_q[2*i].wr, log_q[2*i].addr, log_q[2*i].data, 32'(4*i), 32'(i + 1));
        end
        total++;
        if (log_q[2*i+1] !== '{wr: 1'b1, addr: DST + 32'(4*i), data: 32'(i + 1)}) begin
          bad++;
          $display("FAIL copy_write_%0d: got wr=%b addr=%h data=%h, want W %h %h",
                   i, log_q[2*i+1].wr, log_q[2*i+1].addr, log_q[2*i+1].data, DST + 32'(4*i), 32'(i + 1));
        end
      end
    end
  endtask

  task automatic test_wait_states();
    int seen, sb;
    snap_t f;
    rom[0] = 32'h0000_0010; rom[1] = 32'h0000_0200;
    rom[2] = 32'h0000_3000; rom[3] = 32'h0004_0000;
    log_q.delete();
    run_copy(1'b1, -1, seen, f, sb);
    total++;
    if (seen !== 48) begin
      bad++;
      $display("FAIL wait_done_time: got %0d edges, want 48", seen);
    end
    total++;
    if (sb !== 0) begin
      bad++;
      $display("FAIL wait_stall_hold: got %0d changed stall cycles, want 0", sb);
    end
    total++;
    if (checksum !== 32'h0004_3210) begin
      bad++;
      $display("FAIL wait_checksum: got %h, want 00043210", checksum);
    end
    total++;
    if (log_q.size() !== 8) begin
      bad++;
      $display("FAIL wait_txn_count: got %0d, want 8", log_q.size());
    end
    @(negedge HCLK);
    for (int i = 0; i < WORDS; i++) begin
      total++;
      if (sram[i] !== rom[i]) begin
        bad++;
        $display("FAIL wait_sram_%0d: got %h, want %h", i, sram[i], rom[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int seen, sb;
    snap_t f;
    rom[0] = 32'd1; rom[1] = 32'd2; rom[2] = 32'd3; rom[3] = 32'd4;
    log_q.delete();
    run_copy(1'b0, 5, seen, f, sb);
    total++;
    if (seen !== 16) begin
      bad++;
      $display("FAIL busy_start_done_time: got %0d edges, want 16", seen);
    end
    total++;
    if (checksum !== 32'd10) begin
      bad++;
      $display("FAIL busy_start_checksum: got %h, want 0000000a", checksum);
    end
    repeat (4) @(negedge HCLK);
    total++;
    if (log_q.size() !== 8 || busy !== 1'b0 || done !== 1'b1 || HTRANS !== 2'b00) begin
      bad++;
      $display("FAIL busy_start_single: got txns=%0d busy=%b done=%b htrans=%b, want 8 0 1 00",
               log_q.size(), busy, done, HTRANS);
    end
  endtask

  task automatic test_restart_from_done();
    int seen, sb;
    snap_t f;
    rom[0] = 32'd5; rom[1] = 32'd6; rom[2] = 32'd7; rom[3] = 32'd8;
    run_copy(1'b0, -1, seen, f, sb);
    total++;
    if (f.checksum !== 32'h0 || f.busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_clear: got checksum=%h busy=%b, want 00000000 1", f.checksum, f.busy);
    end
    total++;
    if (seen !== 16 || checksum !== 32'd26) begin
      bad++;
      $display("FAIL restart_result: got edges=%0d checksum=%h, want 16 0000001a", seen, checksum);
    end
  endtask

  task automatic test_checksum_wrap();
    int seen, sb;
    snap_t f;
    rom[0] = 32'hFFFF_FFFF; rom[1] = 32'h0000_0002;
    rom[2] = 32'hFFFF_FFFF; rom[3] = 32'h0000_0001;
    run_copy(1'b0, -1, seen, f, sb);
    total++;
    if (checksum !== 32'h0000_0001) begin
      bad++;
      $display("FAIL wrap_checksum: got %h, want 00000001", checksum);
    end
  endtask

  task automatic test_reset_mid_copy();
    rom[0] = 32'd1; rom[1] = 32'd2; rom[2] = 32'd3; rom[3] = 32'd4;
    @(negedge HCLK);
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    repeat (6) @(negedge HCLK);
    // Cycle 6 after the start edge is the write address phase of word 1.
    total++;
    if (HTRANS !== 2'b10 || HWRITE !== 1'b1 || HADDR !== DST + 32'h4) begin
      bad++;
      $display("FAIL midreset_wr_a: got htrans=%b hwrite=%b haddr=%h, want 10 1 %h", HTRANS, HWRITE, HADDR, DST + 32'h4);
    end
    #1 HRESETn = 1'b0;
    #1;
    total++;
    if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HWDATA !== 32'h0 ||
        busy !== 1'b0 || done !== 1'b0 || checksum !== 32'h0) begin
      bad++;
      $display("FAIL midreset_async: got htrans=%b haddr=%h hwrite=%b hwdata=%h busy=%b done=%b cs=%h, want reset values",
               HTRANS, HADDR, HWRITE, HWDATA, busy, done, checksum);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    log_q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      total++;
      if (HTRANS !== 2'b00 || busy !== 1'b0) begin
        bad++;
        $display("FAIL midreset_quiet: got htrans=%b busy=%b, want 00 0", HTRANS, busy);
      end
    end
    total++;
    if (log_q.size() !== 0) begin
      bad++;
      $display("FAIL midreset_no_txn: got %0d transfers, want 0", log_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    test_reset();
    test_copy();
    test_wait_states();
    test_start_while_busy();
    test_restart_from_done();
    test_checksum_wrap();
    test_reset_mid_copy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
